// File: rtl/enc8_pkg.sv
// Shared types and helpers for the 8-bit sequential set-bit encoder.
// Scan order is chosen at build time by ENC8_PRIO_HIGH_EN (see enc8_prio).
package enc8_pkg;

    localparam int VEC_W = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcnt(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // True for zero or exactly one set bit.
    function automatic logic onehot0(input logic [VEC_W-1:0] v);
        return (v & (v - VEC_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/enc8_prio.sv
// Combinational 8-to-3 priority encoder.
// ENC8_PRIO_HIGH_EN selects highest-bit-first; default is lowest-bit-first.
module enc8_prio
    import enc8_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
`ifdef ENC8_PRIO_HIGH_EN
        for (int i = 0; i < VEC_W; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
`else
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
`endif
        any_o = |vec_i;
    end

endmodule

// File: rtl/enc8_seq.sv
// Sequential set-bit encoder: captures an 8-bit vector, emits one beat per set bit.
// Scan order follows ENC8_PRIO_HIGH_EN (highest first when defined).
module enc8_seq
    import enc8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_cnt
);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [VEC_W-1:0] nxt_vec;
    logic [VEC_W-1:0] clr_mask;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    // Encoder looks at the vector as it will be next cycle
    always_comb begin
        clr_mask        = '0;
        clr_mask[idx_q] = 1'b1;
        if (state_q == IDLE) nxt_vec = in_vec;
        else                 nxt_vec = vec_q & ~clr_mask;
    end

    enc8_prio u_prio (
        .vec_i (nxt_vec),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SCAN;
                    vec_d   = nxt_vec;
                    valid_d = 1'b1;
                    idx_d   = enc_idx;
                    last_d  = onehot0(nxt_vec);
                    zero_d  = !enc_any;
                    cnt_d   = popcnt(nxt_vec);
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        vec_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        vec_d   = nxt_vec;
                        idx_d   = enc_idx;
                        last_d  = onehot0(nxt_vec);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign out_zero  = zero_q;
    assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_enc8_seq.sv
// Directed self-checking bench for enc8_seq; expected orders follow ENC8_PRIO_HIGH_EN.
module tb_enc8_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_zero;
    logic [3:0] out_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    enc8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1ns after the edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        n_checks++;
        if ({out_valid, out_idx, out_last, out_zero, out_cnt} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b i=%0d l=%0b z=%0b c=%0d want all 0",
                     out_valid, out_idx, out_last, out_zero, out_cnt);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        in_vec    = 8'b0000_0100;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_idx, out_last, out_zero, out_cnt, in_ready}
            !== {1'b1, 3'd2, 1'b1, 1'b0, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_beat: got v=%0b i=%0d l=%0b z=%0b c=%0d r=%0b want 1 2 1 0 1 0",
                     out_valid, out_idx, out_last, out_zero, out_cnt, in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: out_valid got %0b want 0", out_valid);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_in_ready_n3: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_multi();
        logic [2:0] exp_idx [3];
`ifdef ENC8_PRIO_HIGH_EN
        exp_idx = '{3'd7, 3'd2, 3'd0};
`else
        exp_idx = '{3'd0, 3'd2, 3'd7};
`endif
        in_valid  = 1'b1;
        in_vec    = 8'b1000_0101;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({out_valid, out_idx, out_last, out_zero, out_cnt}
                !== {1'b1, exp_idx[k], (k == 2), 1'b0, 4'd3}) begin
                n_fail++;
                $display("FAIL multi_beat%0d: got v=%0b i=%0d l=%0b z=%0b c=%0d want 1 %0d %0b 0 3",
                         k, out_valid, out_idx, out_last, out_zero, out_cnt,
                         exp_idx[k], (k == 2));
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_done: out_valid got %0b want 0", out_valid);
        end
        step();
    endtask

    task automatic test_zero();
        in_valid  = 1'b1;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_idx, out_last, out_zero, out_cnt}
            !== {1'b1, 3'd0, 1'b1, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL zero_beat: got v=%0b i=%0d l=%0b z=%0b c=%0d want 1 0 1 1 0",
                     out_valid, out_idx, out_last, out_zero, out_cnt);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: out_valid got %0b want 0", out_valid);
        end
        step();
    endtask

    task automatic test_ff_stall();
        int         k;
        logic [2:0] e;
        k         = 0;
        in_valid  = 1'b1;
        in_vec    = 8'hFF;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            out_ready = (c % 2 == 0);
`ifdef ENC8_PRIO_HIGH_EN
            e = 3'(7 - k);
`else
            e = 3'(k);
`endif
            n_checks++;
            if ({out_valid, out_idx, out_last, out_zero, out_cnt}
                !== {1'b1, e, (k == 7), 1'b0, 4'd8}) begin
                n_fail++;
                $display("FAIL ff_cycle%0d: got v=%0b i=%0d l=%0b z=%0b c=%0d want 1 %0d %0b 0 8",
                         c, out_valid, out_idx, out_last, out_zero, out_cnt, e, (k == 7));
            end
            if (out_valid && out_ready) k++;
            step();
        end
        n_checks++;
        if (k != 8 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_total: beats got %0d want 8, out_valid got %0b want 0", k, out_valid);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_rst_mid();
        logic [2:0] exp_idx [2];
`ifdef ENC8_PRIO_HIGH_EN
        exp_idx = '{3'd7, 3'd6};
`else
        exp_idx = '{3'd4, 3'd5};
`endif
        in_valid  = 1'b1;
        in_vec    = 8'hF0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({out_valid, out_idx, out_last} !== {1'b1, exp_idx[k], 1'b0}) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: got v=%0b i=%0d l=%0b want 1 %0d 0",
                         k, out_valid, out_idx, out_last, exp_idx[k]);
            end
            step();
        end
        // Reset wins over a simultaneous beat and a pending accept
        rst      = 1'b1;
        in_valid = 1'b1;
        in_vec   = 8'hFF;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_cnt} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL rstmid_abort: got v=%0b c=%0d want 0 0", out_valid, out_cnt);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL rstmid_idle%0d: got v=%0b r=%0b want 0 1", c, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_ignore();
        logic [2:0] exp_idx [2];
`ifdef ENC8_PRIO_HIGH_EN
        exp_idx = '{3'd5, 3'd4};
`else
        exp_idx = '{3'd4, 3'd5};
`endif
        in_valid  = 1'b1;
        in_vec    = 8'h30;
        out_ready = 1'b1;
        step();
        in_vec = 8'h01;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({out_valid, out_idx, out_last, out_cnt, in_ready}
                !== {1'b1, exp_idx[k], (k == 1), 4'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL ignore_beat%0d: got v=%0b i=%0d l=%0b c=%0d r=%0b want 1 %0d %0b 2 0",
                         k, out_valid, out_idx, out_last, out_cnt, in_ready, exp_idx[k], (k == 1));
            end
            step();
        end
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL ignore_idle: got v=%0b r=%0b want 0 1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_idx, out_last, out_zero, out_cnt}
            !== {1'b1, 3'd0, 1'b1, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL ignore_next: got v=%0b i=%0d l=%0b z=%0b c=%0d want 1 0 1 0 1",
                     out_valid, out_idx, out_last, out_zero, out_cnt);
        end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_ff_stall();
        test_rst_mid();
        test_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
